lmb_bram_port_cntlr: RTL and testbench

LMB slave responder that fronts one port of the dual-port LMB BRAM block. Decodes MicroBlaze LMB accesses against an address window, drives the BRAM port signals (EN, WEN, Addr, write data), and returns read data with Sl_Ready. Supports an optional read output register and flags illegal byte-enable patterns. One instance per BRAM port: A for ILMB, B for DLMB.

---
 rtl/lmb_bram_port_cntlr.sv | 134 +++++++++++++
 tb/tb_lmb_bram_port_cntlr.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lmb_bram_port_cntlr.sv
// LMB slave front-end for one port of the dual-port LMB BRAM: decodes the
// address window, drives the BRAM port and returns read data with Sl_Ready.
module lmb_bram_port_cntlr #(
   parameter logic [31:0] C_BASEADDR  = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR  = 32'h0000_7FFF,
   parameter logic [31:0] C_MEMSIZE   = 32'h0000_8000,
   parameter int unsigned C_READ_PIPE = 0
) (
   input  logic        LMB_Clk,
   input  logic        LMB_Rst,
   input  logic [0:31] LMB_ABus,
   input  logic [0:31] LMB_WriteDBus,
   input  logic        LMB_AddrStrobe,
   input  logic        LMB_ReadStrobe,
   input  logic        LMB_WriteStrobe,
   input  logic [0:3]  LMB_BE,
   output logic [0:31] Sl_DBus,
   output logic        Sl_Ready,
   output logic        Sl_Wait,
   output logic        Sl_UE,
   output logic        Sl_ProtErr,
   output logic        BRAM_Rst,
   output logic        BRAM_Clk,
   output logic        BRAM_EN,
   output logic [0:3]  BRAM_WEN,
   output logic [0:31] BRAM_Addr,
   output logic [0:31] BRAM_Dout,
   input  logic [0:31] BRAM_Din
);

   typedef enum logic [1:0] {IDLE, RPIPE, RESP} state_e;

   localparam logic [31:0] ADDR_MASK = (C_MEMSIZE - 32'd1) & 32'hFFFF_FFFC;
   localparam logic [31:0] WIN_SPAN  = C_HIGHADDR - C_BASEADDR;

   state_e      state_q;
   logic        ready_q;
   logic        wait_q;
   logic        ue_q;
   logic        rd_q;
   logic        prot_q;
   logic [0:31] rdata_q;

   logic [31:0] win_off;
   logic        in_win;
   logic        be_legal;
   logic        hit;
   logic        is_read;
   logic        bram_en;

   // Offset compare wraps below the base, so one unsigned test covers both bounds.
   always_comb begin
      win_off = LMB_ABus - C_BASEADDR;
      in_win  = (win_off <= WIN_SPAN);
   end

   always_comb begin
      be_legal = 1'b0;
      case (LMB_BE)
         4'b1111, 4'b1100, 4'b0011,
         4'b1000, 4'b0100, 4'b0010, 4'b0001: be_legal = 1'b1;
         default:                            be_legal = 1'b0;
      endcase
   end

   always_comb begin
      hit     = LMB_AddrStrobe & in_win & (state_q == IDLE);
      bram_en = hit & be_legal & ~LMB_Rst;
      is_read = LMB_ReadStrobe & ~LMB_WriteStrobe;
   end

   assign BRAM_Rst  = LMB_Rst;
   assign BRAM_Clk  = LMB_Clk;
   assign BRAM_EN   = bram_en;
   assign BRAM_WEN  = (bram_en & LMB_WriteStrobe) ? LMB_BE : '0;
   assign BRAM_Addr = LMB_ABus & ADDR_MASK;
   assign BRAM_Dout = LMB_WriteDBus;

   always_ff @(posedge LMB_Clk) begin
      if (LMB_Rst) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         wait_q  <= 1'b0;
         ue_q    <= 1'b0;
         rd_q    <= 1'b0;
         prot_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (LMB_AddrStrobe && (state_q != IDLE))
            prot_q <= 1'b1;
         case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               wait_q  <= 1'b0;
               ue_q    <= 1'b0;
               rd_q    <= 1'b0;
               if (hit) begin
                  wait_q <= 1'b1;
                  if (be_legal && is_read && (C_READ_PIPE != 0)) begin
                     state_q <= RPIPE;
                  end else begin
                     state_q <= RESP;
                     ready_q <= 1'b1;
                     ue_q    <= ~be_legal;
                     rd_q    <= be_legal & is_read;
                  end
               end
            end
            RPIPE: begin
               rdata_q <= BRAM_Din;
               state_q <= RESP;
               ready_q <= 1'b1;
               rd_q    <= 1'b1;
            end
            RESP: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               wait_q  <= 1'b0;
               ue_q    <= 1'b0;
               rd_q    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Read data only reaches the bus during a read Ready so slaves can be OR-ed.
   assign Sl_DBus    = (ready_q & rd_q) ? ((C_READ_PIPE != 0) ? rdata_q : BRAM_Din) : '0;
   assign Sl_Ready   = ready_q;
   assign Sl_Wait    = wait_q;
   assign Sl_UE      = ue_q;
   assign Sl_ProtErr = prot_q;

endmodule

// File: tb/tb_lmb_bram_port_cntlr.sv
// Bench for lmb_bram_port_cntlr: one unpiped and one piped instance share the
// LMB stimulus; each fronts its own BRAM model.
module tb_lmb_bram_port_cntlr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] abus, wdbus;
   logic        as_s, rs_s, ws_s;
   logic [3:0]  be;

   logic [31:0] dbus0, dbus1, baddr0, baddr1, bdout0, bdout1, bdin0, bdin1;
   logic        rdy0, rdy1, wt0, wt1, ue0, ue1, pe0, pe1;
   logic        brst0, brst1, bclk0, bclk1, en0, en1;
   logic [3:0]  wen0, wen1;

   lmb_bram_port_cntlr #(.C_READ_PIPE(0)) dut0 (
      .LMB_Clk(clk), .LMB_Rst(rst), .LMB_ABus(abus), .LMB_WriteDBus(wdbus),
      .LMB_AddrStrobe(as_s), .LMB_ReadStrobe(rs_s), .LMB_WriteStrobe(ws_s), .LMB_BE(be),
      .Sl_DBus(dbus0), .Sl_Ready(rdy0), .Sl_Wait(wt0), .Sl_UE(ue0), .Sl_ProtErr(pe0),
      .BRAM_Rst(brst0), .BRAM_Clk(bclk0), .BRAM_EN(en0), .BRAM_WEN(wen0),
      .BRAM_Addr(baddr0), .BRAM_Dout(bdout0), .BRAM_Din(bdin0));

   lmb_bram_port_cntlr #(.C_READ_PIPE(1)) dut1 (
      .LMB_Clk(clk), .LMB_Rst(rst), .LMB_ABus(abus), .LMB_WriteDBus(wdbus),
      .LMB_AddrStrobe(as_s), .LMB_ReadStrobe(rs_s), .LMB_WriteStrobe(ws_s), .LMB_BE(be),
      .Sl_DBus(dbus1), .Sl_Ready(rdy1), .Sl_Wait(wt1), .Sl_UE(ue1), .Sl_ProtErr(pe1),
      .BRAM_Rst(brst1), .BRAM_Clk(bclk1), .BRAM_EN(en1), .BRAM_WEN(wen1),
      .BRAM_Addr(baddr1), .BRAM_Dout(bdout1), .BRAM_Din(bdin1));

   // Synchronous read-first BRAM models, 8K words each.
   logic [31:0] mem0 [0:8191];
   logic [31:0] mem1 [0:8191];
   logic [31:0] ref_mem [0:8191];

   always @(posedge clk) begin
      if (en0) begin
         bdin0 <= mem0[baddr0[14:2]];
         for (int k = 0; k < 4; k++)
            if (wen0[k]) mem0[baddr0[14:2]][8*k +: 8] <= bdout0[8*k +: 8];
      end
   end

   always @(posedge clk) begin
      if (en1) begin
         bdin1 <= mem1[baddr1[14:2]];
         for (int k = 0; k < 4; k++)
            if (wen1[k]) mem1[baddr1[14:2]][8*k +: 8] <= bdout1[8*k +: 8];
      end
   end

   int checks = 0;
   int errors = 0;
   logic exp_prot = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit legal_be(input logic [3:0] b);
      return b inside {4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
   endfunction

   function automatic bit in_range(input logic [31:0] a);
      return a < 32'h0000_8000;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] b, input logic wr);
      if (in_range(a) && legal_be(b) && wr)
         for (int k = 0; k < 4; k++)
            if (b[k]) ref_mem[a[14:2]][8*k +: 8] = wd[8*k +: 8];
   endtask

   // One access from an idle start; follows both instances through T+3.
   task automatic check_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                               input logic rd, input logic wr,
                               input logic x_en, input logic [3:0] x_wen, input logic [31:0] x_baddr,
                               input logic x_rdy, input logic x_ue, input logic [31:0] x_dbus);
      logic piped;
      piped = x_rdy && !x_ue && !wr;
      @(negedge clk);
      abus = a; wdbus = wd; be = b; rs_s = rd; ws_s = wr; as_s = 1'b1;
      #1;
      chk("en0", en0, x_en);           chk("en1", en1, x_en);
      chk("wen0", wen0, x_wen);        chk("wen1", wen1, x_wen);
      chk("baddr0", baddr0, x_baddr);  chk("baddr1", baddr1, x_baddr);
      chk("dout0", bdout0, wd);
      @(negedge clk);
      as_s = 1'b0; rs_s = 1'b0; ws_s = 1'b0; be = 4'b0000;
      #1;
      chk("t1_rdy0", rdy0, x_rdy);     chk("t1_wait0", wt0, x_rdy);
      chk("t1_ue0", ue0, x_ue);        chk("t1_dbus0", dbus0, x_dbus);
      chk("t1_prot0", pe0, exp_prot);  chk("t1_prot1", pe1, exp_prot);
      chk("t1_rdy1", rdy1, piped ? 1'b0 : x_rdy);
      chk("t1_wait1", wt1, x_rdy);
      chk("t1_ue1", ue1, x_ue);
      chk("t1_dbus1", dbus1, piped ? 32'h0 : x_dbus);
      @(negedge clk);
      #1;
      chk("t2_rdy0", rdy0, 1'b0);      chk("t2_wait0", wt0, 1'b0);
      chk("t2_dbus0", dbus0, 32'h0);
      chk("t2_rdy1", rdy1, piped);     chk("t2_wait1", wt1, piped);
      chk("t2_ue1", ue1, 1'b0);
      chk("t2_dbus1", dbus1, piped ? x_dbus : 32'h0);
      @(negedge clk);
      #1;
      chk("t3_rdy1", rdy1, 1'b0);      chk("t3_dbus1", dbus1, 32'h0);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        rd;
      logic        wr;
      logic        en;
      logic [3:0]  wen;
      logic [31:0] baddr;
      logic        rdy;
      logic        ue;
      logic [31:0] dbus;
   } vec_t;

   vec_t tab [14];
   logic [3:0] legal_tab [7];

   initial begin
      logic [31:0] a, wd;
      logic [3:0]  b;
      logic        rd, wr, ok, hit;
      int unsigned r;

      for (int i = 0; i < 8192; i++) begin
         mem0[i] = '0; mem1[i] = '0; ref_mem[i] = '0;
      end
      bdin0 = '0; bdin1 = '0;
      legal_tab = '{4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

      //          addr          wdata         be       rd    wr    en    wen      baddr         rdy   ue    dbus
      tab[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0000};
      tab[1]  = '{32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0000_0010, 1'b1, 1'b0, 32'hDEAD_BEEF};
      tab[2]  = '{32'h0000_0022, 32'h1234_5678, 4'b0011, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0000};
      tab[3]  = '{32'h0000_0020, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_5678};
      tab[4]  = '{32'h0000_0020, 32'hFFFF_FFFF, 4'b0110, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0000};
      tab[5]  = '{32'h0000_0022, 32'h0000_0000, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_5678};
      tab[6]  = '{32'h0000_8000, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
      tab[7]  = '{32'h0000_7FFC, 32'hAB00_0000, 4'b1000, 1'b0, 1'b1, 1'b1, 4'b1000, 32'h0000_7FFC, 1'b1, 1'b0, 32'h0000_0000};
      tab[8]  = '{32'h0000_7FFF, 32'h0000_0000, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0000_7FFC, 1'b1, 1'b0, 32'hAB00_0000};
      tab[9]  = '{32'h0000_0014, 32'h1122_3344, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h0000_0014, 1'b1, 1'b0, 32'h0000_0000};
      tab[10] = '{32'h0000_0014, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0000_0014, 1'b1, 1'b0, 32'h1122_3344};
      tab[11] = '{32'h0000_8004, 32'h5555_5555, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0000};
      tab[12] = '{32'h0000_0010, 32'h0000_0000, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0000_0010, 1'b1, 1'b0, 32'hDEAD_BEEF};
      tab[13] = '{32'h0000_0010, 32'h0000_0000, 4'b1010, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0000};

      rst = 1'b1; abus = '0; wdbus = '0; as_s = 1'b0; rs_s = 1'b0; ws_s = 1'b0; be = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rdy0", rdy0, 1'b0);  chk("rst_rdy1", rdy1, 1'b0);
      chk("rst_wait1", wt1, 1'b0);  chk("rst_prot0", pe0, 1'b0);
      chk("rst_dbus1", dbus1, 32'h0);
      chk("rst_bram_rst", brst0, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      foreach (tab[i]) begin
         check_access(tab[i].addr, tab[i].wd, tab[i].be, tab[i].rd, tab[i].wr,
                      tab[i].en, tab[i].wen, tab[i].baddr, tab[i].rdy, tab[i].ue, tab[i].dbus);
         model_write(tab[i].addr, tab[i].wd, tab[i].be, tab[i].wr);
      end

      // Strobe during a busy piped read: ignored by both, ProtErr becomes sticky.
      @(negedge clk);
      abus = 32'h10; be = 4'b1111; rs_s = 1'b1; ws_s = 1'b0; as_s = 1'b1;
      @(negedge clk);
      abus = 32'h30; wdbus = 32'h5555_5555; rs_s = 1'b0; ws_s = 1'b1; as_s = 1'b1;
      #1;
      chk("busy_en0", en0, 1'b0);   chk("busy_en1", en1, 1'b0);
      chk("busy_wen1", wen1, 4'b0000);
      @(negedge clk);
      as_s = 1'b0; ws_s = 1'b0; be = '0;
      #1;
      chk("busy_prot0", pe0, 1'b1); chk("busy_prot1", pe1, 1'b1);
      chk("busy_rdy1", rdy1, 1'b1); chk("busy_dbus1", dbus1, ref_mem[4]);
      exp_prot = 1'b1;
      repeat (2) @(negedge clk);
      check_access(32'h30, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h30, 1'b1, 1'b0, ref_mem[12]);

      // Reset in the middle of a piped read drops it and clears all flags.
      @(negedge clk);
      abus = 32'h10; be = 4'b1111; rs_s = 1'b1; as_s = 1'b1;
      @(negedge clk);
      as_s = 1'b0; rs_s = 1'b0; rst = 1'b1;
      #1;
      chk("rst_mid_rdy1", rdy1, 1'b0); chk("rst_mid_wait1", wt1, 1'b1);
      @(negedge clk);
      #1;
      chk("rst_end_rdy1", rdy1, 1'b0); chk("rst_end_wait1", wt1, 1'b0);
      chk("rst_end_prot0", pe0, 1'b0); chk("rst_end_prot1", pe1, 1'b0);
      chk("rst_end_dbus1", dbus1, 32'h0); chk("rst_end_ue0", ue0, 1'b0);
      abus = 32'h40; wdbus = 32'hFFFF_FFFF; be = 4'b1111; ws_s = 1'b1; as_s = 1'b1;
      #1;
      chk("rst_en0", en0, 1'b0);    chk("rst_en1", en1, 1'b0);
      chk("rst_wen0", wen0, 4'b0000);
      @(negedge clk);
      rst = 1'b0; as_s = 1'b0; ws_s = 1'b0;
      #1;
      chk("post_rst_rdy1", rdy1, 1'b0);
      exp_prot = 1'b0;
      check_access(32'h40, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h40, 1'b1, 1'b0, ref_mem[16]);
      check_access(32'h10, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h10, 1'b1, 1'b0, ref_mem[4]);

      // Randomised accesses against the reference memory.
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 99);
         if (r < 70)      a = 32'($urandom_range(0, 32'h7FFF));
         else if (r < 85) a = 32'h7FF0 + 32'($urandom_range(0, 31));
         else             a = $urandom;
         b  = ($urandom_range(0, 9) < 7) ? legal_tab[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         wd = $urandom;
         hit = in_range(a);
         ok  = hit && legal_be(b);
         check_access(a, wd, b, rd, wr, ok, (ok && wr) ? b : 4'b0000, a & 32'h7FFC,
                      hit, hit && !ok, (ok && !wr) ? ref_mem[a[14:2]] : 32'h0);
         model_write(a, wd, b, wr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
